// File: rtl/fsm_cmd_driver_if.sv
// Request/response and controller-side bundle for fsm_cmd_driver.
// The slave view is the driver; master is the environment (sequencer plus controller status).
interface fsm_cmd_driver_if #(
    parameter int unsigned HOLD_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_target;
    logic [HOLD_W-1:0] req_hold;
    logic [1:0]        cmd;
    logic [1:0]        status;
    logic              rsp_valid;
    logic              rsp_err;
    logic [1:0]        rsp_status;
    logic              busy;

    modport slave (
        input  req_valid, req_target, req_hold, status,
        output req_ready, cmd, rsp_valid, rsp_err, rsp_status, busy
    );

    modport master (
        output req_valid, req_target, req_hold, status,
        input  req_ready, cmd, rsp_valid, rsp_err, rsp_status, busy
    );
endinterface

// File: rtl/fsm_cmd_driver.sv
// Drives the Blue/Red controller to a requested state with one toggle, confirms it,
// holds it for a requested number of cycles and returns a one-cycle response.
module fsm_cmd_driver #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned HOLD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fsm_cmd_driver_if.slave   bus_if
);
    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0] ST_BLUE = 2'h1;
    localparam logic [1:0] ST_RED  = 2'h2;
    localparam logic [1:0] CMD_NOP = 2'h0;
    localparam logic [1:0] CMD_TGL = 2'h1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PULSE, S_WAIT, S_HOLD, S_RESP
    } state_e;

    state_e            state_q;
    logic              tgt_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [1:0]        cmd_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [1:0]        rsp_status_q;
    logic              busy_q;
    logic              ready_q;

    logic              st_valid_c;
    logic              st_match_c;
    logic              to_resp_c;
    logic              resp_err_c;

    assign st_valid_c = (bus_if.status == ST_BLUE) || (bus_if.status == ST_RED);
    assign st_match_c = (bus_if.status == (tgt_q ? ST_RED : ST_BLUE));

    // Terminating decisions shared by CHECK, WAIT and HOLD
    always_comb begin
        to_resp_c  = 1'b0;
        resp_err_c = 1'b0;
        case (state_q)
            S_CHECK: begin
                if (!st_valid_c) begin
                    to_resp_c  = 1'b1;
                    resp_err_c = 1'b1;
                end else if (st_match_c && (hold_q == '0)) begin
                    to_resp_c  = 1'b1;
                end
            end
            S_WAIT: begin
                if (st_match_c) begin
                    to_resp_c  = (hold_q == '0);
                end else if (!st_valid_c || (tmo_cnt_q == TMO_LAST)) begin
                    to_resp_c  = 1'b1;
                    resp_err_c = 1'b1;
                end
            end
            S_HOLD: begin
                if (!st_match_c) begin
                    to_resp_c  = 1'b1;
                    resp_err_c = 1'b1;
                end else if (hold_cnt_q == HOLD_W'(1)) begin
                    to_resp_c  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            hold_q       <= '0;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            cmd_q        <= CMD_NOP;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_status_q <= 2'h0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            // cmd and rsp_valid are single-cycle pulses
            cmd_q       <= CMD_NOP;
            rsp_valid_q <= 1'b0;
            if (to_resp_c) begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_err_q    <= resp_err_c;
                rsp_status_q <= bus_if.status;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus_if.req_valid) begin
                            state_q <= S_CHECK;
                            tgt_q   <= bus_if.req_target;
                            hold_q  <= bus_if.req_hold;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (st_match_c) begin
                            state_q    <= S_HOLD;
                            hold_cnt_q <= hold_q;
                        end else begin
                            state_q <= S_PULSE;
                            cmd_q   <= CMD_TGL;
                        end
                    end
                    S_PULSE: begin
                        state_q   <= S_WAIT;
                        tmo_cnt_q <= '0;
                    end
                    S_WAIT: begin
                        if (st_match_c) begin
                            state_q    <= S_HOLD;
                            hold_cnt_q <= hold_q;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                    S_HOLD: begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                    S_RESP: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_if.cmd        = cmd_q;
    assign bus_if.rsp_valid  = rsp_valid_q;
    assign bus_if.rsp_err    = rsp_err_q;
    assign bus_if.rsp_status = rsp_status_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.req_ready  = ready_q;
endmodule

// File: tb/tb_fsm_cmd_driver.sv
// Bench for fsm_cmd_driver: a Blue/Red controller model (with status override) plus
// a vector table and hand-written corner sequences, checked through a response scoreboard.
module tb_fsm_cmd_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fsm_cmd_driver_if #(.HOLD_W(4)) bus();

    fsm_cmd_driver #(.TIMEOUT(8), .HOLD_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Controller model: resets to Red, toggles on cmd=1; frozen while status is overridden
    logic [1:0] model_st;
    logic       force_en;
    logic [1:0] force_val;
    always @(posedge clk or posedge rst) begin
        if (rst)                               model_st <= 2'h2;
        else if (!force_en && bus.cmd == 2'h1) model_st <= (model_st == 2'h1) ? 2'h2 : 2'h1;
    end
    assign bus.status = force_en ? force_val : model_st;

    typedef struct {
        logic       err;
        logic [1:0] st;
        int         lat;
        int         pulses;
        int         pulse_cyc;
    } exp_t;

    typedef struct {
        logic       tgt;
        logic [3:0] hold;
        logic       fen;
        logic [1:0] fval;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nerr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Issue one request, watch it to completion, then compare against the scoreboard
    task automatic run_req(input string nm, input logic tgt, input logic [3:0] hold,
                           input int keep_valid, input int flip_cyc, input exp_t e);
        int         rcyc = 0;
        int         np   = 0;
        int         pc   = 0;
        bit         got  = 0;
        logic       rerr = 1'b0;
        logic [1:0] rst_v = 2'h0;
        exp_t       x;
        sb.push_back(e);
        bus.req_target = tgt;
        bus.req_hold   = hold;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            bus.req_valid = (cyc <= keep_valid);
            if (cyc == flip_cyc) begin force_en = 1'b1; force_val = 2'h1; end
            @(negedge clk);
            if (cyc == 1) check({nm, ".busy_ready_c1"}, 32'({bus.busy, bus.req_ready}), 32'b10);
            if (bus.cmd == 2'h1) begin np++; pc = cyc; end
            if (bus.rsp_valid) begin
                got = 1; rcyc = cyc; rerr = bus.rsp_err; rst_v = bus.rsp_status;
            end
        end
        bus.req_valid = 1'b0;
        x = sb.pop_front();
        if (!got) begin
            nchecks++; nerr++;
            $display("FAIL %s.timeout: no rsp_valid within 40 cycles, expected cycle %0d", nm, x.lat);
        end else begin
            check({nm, ".rsp_cycle"},  32'(rcyc),  32'(x.lat));
            check({nm, ".rsp_err"},    32'(rerr),  32'(x.err));
            check({nm, ".rsp_status"}, 32'(rst_v), 32'(x.st));
        end
        check({nm, ".pulses"}, 32'(np), 32'(x.pulses));
        if (x.pulses > 0) check({nm, ".pulse_cycle"}, 32'(pc), 32'(x.pulse_cyc));
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, ".idle_after"}, 32'({bus.busy, bus.req_ready, bus.rsp_valid, bus.cmd}), 32'b01000);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {tgt, hold, force_en, force_val, {err, status, rsp_cycle, pulses, pulse_cycle}}
        vecs[0] = '{1'b1, 4'd0,  1'b0, 2'h0, '{1'b0, 2'h2, 2,  0, 0}};  // already Red
        vecs[1] = '{1'b0, 4'd3,  1'b0, 2'h0, '{1'b0, 2'h1, 7,  1, 2}};  // toggle to Blue, hold 3
        vecs[2] = '{1'b0, 4'd0,  1'b0, 2'h0, '{1'b0, 2'h1, 2,  0, 0}};  // already Blue
        vecs[3] = '{1'b1, 4'd0,  1'b0, 2'h0, '{1'b0, 2'h2, 4,  1, 2}};  // toggle to Red
        vecs[4] = '{1'b0, 4'd0,  1'b1, 2'h2, '{1'b1, 2'h2, 11, 1, 2}};  // stuck Red: timeout
        vecs[5] = '{1'b1, 4'd0,  1'b1, 2'h3, '{1'b1, 2'h3, 2,  0, 0}};  // invalid 3 at CHECK
        vecs[6] = '{1'b1, 4'd2,  1'b1, 2'h0, '{1'b1, 2'h0, 2,  0, 0}};  // invalid 0 at CHECK
        vecs[7] = '{1'b1, 4'd1,  1'b0, 2'h0, '{1'b0, 2'h2, 3,  0, 0}};  // minimum hold
        vecs[8] = '{1'b1, 4'd15, 1'b0, 2'h0, '{1'b0, 2'h2, 17, 0, 0}};  // maximum hold

        rst = 1'b1;
        force_en = 1'b0; force_val = 2'h0;
        bus.req_valid = 1'b0; bus.req_target = 1'b0; bus.req_hold = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              32'({bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_status, bus.cmd}),
              32'b0_1_0_0_00_00);

        for (int i = 0; i < 9; i++) begin
            force_en  = vecs[i].fen;
            force_val = vecs[i].fval;
            run_req($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].hold, 0, 0, vecs[i].e);
            force_en  = 1'b0;
        end

        // Status flips during the 2nd HOLD cycle; req_valid kept high while busy
        run_req("hold_flip", 1'b1, 4'd5, 3, 3, '{1'b1, 2'h1, 4, 0, 0});
        force_en = 1'b0;

        // Reset during WAIT abandons the request
        force_en = 1'b1; force_val = 2'h2;
        bus.req_target = 1'b0; bus.req_hold = 4'd0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstwait.in_wait", 32'({bus.busy, bus.cmd}), 32'b100);
        #2 rst = 1'b1;
        #1 check("rstwait.async_outputs", 32'({bus.busy, bus.req_ready, bus.cmd}), 32'b0100);
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (bus.rsp_valid) seen++;
            end
            force_en = 1'b0;
            rst = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.rsp_valid) seen++;
            end
            check("rstwait.no_rsp", 32'(seen), 32'd0);
        end
        check("rstwait.ready_after", 32'({bus.busy, bus.req_ready}), 32'b01);
        run_req("after_rst", 1'b0, 4'd2, 0, 0, '{1'b0, 2'h1, 6, 1, 2});

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/fsm_cmd_driver.md
# fsm_cmd_driver

Command-side driver for the two-state Color controller (states Blue/Red, 2-bit command input, 2-bit status output). Accepts a request for a target state over a valid/ready handshake, issues the single-cycle toggle command needed to reach it, waits for the controller's status to confirm, holds the state for a requested number of cycles, and returns a one-cycle response with an error flag. It sits between the sequencing logic and the controller, driving the controller's command input and reading its status output.

## Interface
- TIMEOUT, 8: maximum WAIT cycles for status to confirm after a toggle; legal range 1..255.
- HOLD_W, 4: width of the hold-count field.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request; high only in IDLE.
- req_target  in  1  target state: 0 = Blue, 1 = Red.
- req_hold  in  HOLD_W  number of cycles to hold the target after it is reached.
- cmd  out  2  command to the controller: 2'h0 = no-op/stay, 2'h1 = toggle.
- status  in  2  controller status: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are invalid.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  response error flag; qualified by rsp_valid.
- rsp_status  out  2  status sampled on the final decision cycle; qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- Controller behaviour the driver relies on: reset state Red (status 2'h2). Command 2'h1 toggles Blue to Red or Red to Blue. Command 2'h0 keeps the current state. Status changes one cycle after the command is sampled.
- States: IDLE, CHECK, PULSE, WAIT, HOLD, RESP.
- IDLE: req_ready=1, cmd=0. When req_valid&req_ready, latch req_target and req_hold, then go to CHECK. req_valid in any other state is ignored and does not stall.
- CHECK: decode status.
  - Invalid status: RESP with err=1.
  - Status matches target: go to HOLD if hold≠0, otherwise RESP with err=0.
  - Status does not match: PULSE.
- PULSE: cmd=2'h1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: cmd=0.
  - Status matches target: HOLD, or RESP (err=0) if hold=0.
  - Status invalid: RESP with err=1.
  - Timeout counter equals TIMEOUT-1: RESP with err=1.
  - Otherwise increment the counter.
  - The driver never re-issues a toggle within one request.
- HOLD: cmd=0; lasts exactly hold cycles via a down-counter. If status differs from target in any HOLD cycle, go to RESP with err=1 on the next cycle. When the count is exhausted, go to RESP with err=0.
- RESP: rsp_valid=1 for one cycle, with rsp_err and rsp_status valid. Then go to IDLE.
- rsp_err and rsp_status are registered and hold their value until the next RESP. Testbenches check them only when rsp_valid=1.
- Reset values: state IDLE, cmd=2'h0, rsp_valid=0, rsp_err=0, rsp_status=2'h0, busy=0, req_ready=1, all counters 0.
- Reset mid-operation: the request is abandoned and no response is produced. cmd returns to 0 immediately (asynchronous).

## Timing
- Cycle 0 is the accepting edge. The state is CHECK during cycle 1.
- Already at target, hold=0: RESP in cycle 2.
- Toggle needed: PULSE in cycle 2 (cmd=1), first WAIT in cycle 3. With a well-behaved controller the status matches in cycle 3, giving RESP in cycle 4 when hold=0, or RESP in cycle 4+hold.
- Timeout: WAIT occupies cycles 3..3+TIMEOUT-1, then RESP in cycle 3+TIMEOUT.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE), so the minimum request period is 3 cycles.
- cmd, rsp_valid, req_ready and busy are decoded from registered state only, with no combinational path from status or req_valid.

## Test plan
- After reset (status 2'h2), request target=Red, hold=0: cmd stays 0 throughout; rsp_valid in cycle 2 with err=0, rsp_status=2'h2.
- Connected to a controller model, request target=Blue, hold=3: cmd=2'h1 only in cycle 2; status=2'h1 from cycle 3; rsp_valid in cycle 7 with err=0, rsp_status=2'h1.
- Status forced to 2'h2, target=Blue, TIMEOUT=8: exactly one cmd pulse (cycle 2); rsp_valid in cycle 11 with err=1, rsp_status=2'h2.
- Status forced to 2'h3 at CHECK: no cmd pulse; rsp_valid in cycle 2 with err=1, rsp_status=2'h3.
- Target=Red, hold=5, status flipped to 2'h1 in the 2nd HOLD cycle: rsp_valid on the following cycle with err=1; req_valid asserted during busy is not accepted.
- rst asserted during WAIT: cmd drops to 0 immediately, no rsp_valid; after release req_ready=1 and a fresh request completes normally.
